mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store stage directly downstream of the ALU: consumes the ALU result as a byte address.
//  Drives a word-wide data memory through a req/ready handshake and handles byte lanes.
//  Sign/zero-extends load data for writeback and stalls the core (busy) while an access is in flight.
// PARAMETERS
//  ADDR_WIDTH      16  word-address width of memAddr (byte address bits [ADDR_WIDTH+1:2])
//  TIMEOUT_CYCLES  64  max cycles waiting for memReady before abort; 0 = no timeout
// PORTS
//  clock          in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  start          in   1   1-cycle request: memory op in current instruction
//  op             in   3   0 LB,1 LBU,2 LH,3 LHU,4 LW,5 SB,6 SH,7 SW
//  address        in   32  byte address (ALU result)
//  storeData      in   32  rt value for stores
//  busy           out  1   stall core; = start | (state==ACCESS)
//  done           out  1   1-cycle pulse, access finished (ok or error)
//  error          out  1   valid with done: timeout (or misalign, see CONFIGURATION)
//  loadData       out  32  extended load result, held until next load completes
//  memAddr        out  ADDR_WIDTH  word address = address[ADDR_WIDTH+1:2]
//  memWriteData   out  32  lane-replicated store data
//  memByteEnable  out  4   active lanes, bit i = byte i (little-endian)
//  memRead        out  1   read strobe, held until memReady
//  memWrite       out  1   write strobe, held until memReady
//  memReady       in   1   memory completes access in this cycle
// BEHAVIOUR
//  FSM: IDLE -> ACCESS -> DONE -> IDLE. All outputs except busy are registered.
//  IDLE: on start, latch op/address/storeData; go to ACCESS; start while not IDLE is ignored.
//  ACCESS: memRead (loads) or memWrite (stores) =1; memAddr/WriteData/ByteEnable stable.
//  ACCESS exit: memReady sampled 1 -> DONE. Loads register extended data into loadData.
//  Min latency: start at t, strobe at t+1, memReady at t+1, done at t+2.
//  DONE: done=1 for one cycle, strobes 0, busy 0 (unless start), then IDLE.
//  A start in DONE is ignored; the core never issues one there.
//  Lanes: SB data={4{b}}, BE=1<<addr[1:0]; SH data={2{h}}, BE=addr[1]?1100:0011; SW BE=1111.
//  Loads: LB/LBU pick byte addr[1:0]; LH/LHU pick half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
//  Stores never modify loadData.
//  Misaligned without macro: LH/SH ignore addr[0]; LW/SW ignore addr[1:0].
//  Timeout: 16-bit counter clears on entering ACCESS, +1 per ACCESS cycle without memReady.
//  Timeout abort: counter == TIMEOUT_CYCLES-1 without memReady -> drop strobes, DONE with error=1.
//  On timeout abort, loadData is unchanged. memReady in the same cycle as the limit wins (no error).
//  memReady outside ACCESS is ignored.
//  Reset (async, any state): state IDLE; all outputs 0 (busy = start); in-flight access abandoned.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: misaligned halfword (addr[0]) or word (addr[1:0]!=0) access on start:
//    no strobe issued; FSM goes IDLE->DONE directly; done=1, error=1 at t+1; loadData unchanged.
//  MISALIGN_TRAP_EN undefined: no check; address low bits truncated as above; error only from timeout.
// TESTING
//  SW addr 0x104 data 0xDEADBEEF, memReady at t+1 -> memAddr=0x41, BE=1111, done at t+2, error=0.
//  LB addr 0x103, mem word 0x80112233 -> BE ignored, loadData=0xFFFFFF80; LBU -> 0x00000080.
//  SH addr 0x102 data 0x0000A5C3 -> memWriteData=0xA5C3A5C3, BE=1100; LH same addr reads 0xFFFFA5C3.
//  memReady held low, TIMEOUT_CYCLES=4 -> strobe 4 cycles, done+error, loadData unchanged, busy drops.
//  reset low mid-ACCESS -> memRead=0 immediately; next start after release behaves normally.
//  MISALIGN_TRAP_EN: LW addr 0x102 -> no memRead; done+error at t+1. Undefined: reads word 0x40.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store stage: byte-addressed access to a word-wide memory over req/ready.
// Build option MISALIGN_TRAP_EN: trap misaligned half/word accesses with error.
module mem_access_unit #(
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [31:0]           address,
   input  logic [31:0]           storeData,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [31:0]           loadData,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic [31:0]           memWriteData,
   output logic [3:0]            memByteEnable,
   output logic                  memRead,
   output logic                  memWrite,
   input  logic                  memReady,
   input  logic [31:0]           memReadData
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic        TO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [2:0]  op_q;
   logic [1:0]  lane_q;
   logic [15:0] cnt;
   logic        accept, tmo, mis, is_store;
   logic [31:0] wdata_d, shifted, ext;
   logic [3:0]  be_d;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic        unused_ok;

   assign unused_ok = ^address[31:ADDR_WIDTH+2];
   assign is_store  = op[2] & (op[1] | op[0]);
   assign busy      = start | (state == ACCESS);

`ifdef MISALIGN_TRAP_EN
   always_comb begin
      mis = 1'b0;
      case (op)
         3'd2, 3'd3, 3'd6: mis = address[0];
         3'd4, 3'd7:       mis = |address[1:0];
         default:          mis = 1'b0;
      endcase
   end
`else
   assign mis = 1'b0;
`endif

   always_comb begin
      wdata_d = storeData;
      be_d    = 4'b1111;
      case (op)
         3'd0, 3'd1, 3'd5: begin
            wdata_d = {4{storeData[7:0]}};
            be_d    = 4'b0001 << address[1:0];
         end
         3'd2, 3'd3, 3'd6: begin
            wdata_d = {2{storeData[15:0]}};
            be_d    = address[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted = memReadData >> {lane_q, 3'b000};
      byte_v  = shifted[7:0];
      half_v  = lane_q[1] ? memReadData[31:16] : memReadData[15:0];
      ext     = memReadData;
      case (op_q)
         3'd0:    ext = {{24{byte_v[7]}}, byte_v};
         3'd1:    ext = {24'd0, byte_v};
         3'd2:    ext = {{16{half_v[15]}}, half_v};
         3'd3:    ext = {16'd0, half_v};
         default: ext = memReadData;
      endcase
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      tmo       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept    = ~mis;
               state_nxt = mis ? DONE : ACCESS;
            end
         end
         ACCESS: begin
            if (memReady) begin
               state_nxt = DONE;
            end else if (TO_EN && cnt == LIMIT) begin
               tmo       = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_q          <= 3'd0;
         lane_q        <= 2'd0;
         cnt           <= 16'd0;
         done          <= 1'b0;
         error         <= 1'b0;
         loadData      <= 32'd0;
         memAddr       <= '0;
         memWriteData  <= 32'd0;
         memByteEnable <= 4'd0;
         memRead       <= 1'b0;
         memWrite      <= 1'b0;
      end else begin
         done  <= (state_nxt == DONE);
         error <= tmo | (state == IDLE && start && mis);
         if (state == IDLE && start) begin
            op_q          <= op;
            lane_q        <= address[1:0];
            memAddr       <= address[ADDR_WIDTH+1:2];
            memWriteData  <= wdata_d;
            memByteEnable <= be_d;
            memRead       <= ~mis & ~is_store;
            memWrite      <= ~mis & is_store;
         end
         if (accept) begin
            cnt <= 16'd0;
         end else if (state == ACCESS && !memReady) begin
            cnt <= cnt + 16'd1;
         end
         if (state == ACCESS && (memReady || tmo)) begin
            memRead  <= 1'b0;
            memWrite <= 1'b0;
         end
         // memWrite still set here means the finishing access was a store
         if (state == ACCESS && memReady && !memWrite) begin
            loadData <= ext;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random ops vs a memory model.
// Uses TIMEOUT_CYCLES=4 so timeouts are reachable with short latencies.
module tb_mem_access_unit;

   localparam int T = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] address = 32'd0;
   logic [31:0] storeData = 32'd0;
   logic        busy, done, error;
   logic [31:0] loadData;
   logic [15:0] memAddr;
   logic [31:0] memWriteData;
   logic [3:0]  memByteEnable;
   logic        memRead, memWrite;
   logic        memReady = 1'b0;
   logic [31:0] memReadData = 32'd0;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mem [64];
   logic [31:0] exp_ld = 32'd0;

   mem_access_unit #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(T)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .address(address), .storeData(storeData), .busy(busy),
      .done(done), .error(error), .loadData(loadData),
      .memAddr(memAddr), .memWriteData(memWriteData),
      .memByteEnable(memByteEnable), .memRead(memRead),
      .memWrite(memWrite), .memReady(memReady),
      .memReadData(memReadData)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] o);
      if (o == 0 || o == 1 || o == 5) return 1;
      if (o == 2 || o == 3 || o == 6) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] o,
                                              input logic [31:0] a,
                                              input logic [31:0] w);
      int unsigned b, h;
      b = (w >> (8 * a[1:0])) & 32'hFF;
      h = a[1] ? (w >> 16) : (w & 32'hFFFF);
      case (o)
         3'd0:    return (b >= 128) ? b - 256 : b;
         3'd1:    return b;
         3'd2:    return (h >= 32768) ? h - 65536 : h;
         3'd3:    return h;
         default: return w;
      endcase
   endfunction

   // lat: cycles of strobe before memReady is given
   task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] d, input int lat);
      int          sz, first, n, idx;
      logic        st, err, mis;
      logic [31:0] w, ewd;
      logic [3:0]  ebe;
      sz    = size_of(o);
      st    = (o >= 5);
      idx   = (a >> 2) & 63;
      first = (sz == 1) ? a[1:0] : (sz == 2) ? 2 * a[1] : 0;
      ewd   = 32'd0;
      ebe   = 4'd0;
      for (int i = 0; i < sz; i++) begin
         ebe[first + i] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         ewd[8*i +: 8] = d[8 * (i % sz) +: 8];
      end
      mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'd0);
`endif
      @(negedge clock);
      start = 1'b1; op = o; address = a; storeData = d;
      #1 check("busy_start", busy, 1);
      @(negedge clock);
      start = 1'b0;
      if (mis) begin
         check("mis_done", {done, error, memRead, memWrite}, 4'b1100);
      end else begin
         n   = (lat < T) ? lat + 1 : T;
         err = (lat >= T);
         for (int k = 0; k < n; k++) begin
            check("strobe", {memRead, memWrite, busy}, {~st, st, 1'b1});
            check("addr", memAddr, a[17:2]);
            if (st) begin
               check("wdata", memWriteData, ewd);
               check("be", memByteEnable, ebe);
            end
            if (k == lat) begin
               memReady = 1'b1;
               memReadData = mem[idx];
               if (st) begin
                  w = mem[idx];
                  for (int i = 0; i < sz; i++) begin
                     w[8*(first+i) +: 8] = d[8*i +: 8];
                  end
                  mem[idx] = w;
               end else begin
                  exp_ld = model_load(o, a, mem[idx]);
               end
            end
            @(negedge clock);
            memReady = 1'b0;
            memReadData = $urandom;
         end
         check("done", {done, error, memRead, memWrite, busy},
               {1'b1, err, 3'b000});
      end
      check("loadData", loadData, exp_ld);
      @(negedge clock);
      check("done_clr", {done, error}, 2'b00);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      repeat (2) @(negedge clock);
      check("rst_out", {busy, done, error, memRead, memWrite, memByteEnable},
            9'd0);
      check("rst_ld", loadData, 0);
      check("rst_addr", {memAddr, memWriteData[15:0]}, 0);
      reset = 1'b1;

      do_op(3'd7, 32'h104, 32'hDEADBEEF, 0);
      check("sw_mem", mem[(32'h104 >> 2) & 63], 32'hDEADBEEF);
      mem[(32'h103 >> 2) & 63] = 32'h80112233;
      do_op(3'd0, 32'h103, 32'h0, 1);
      check("lb_const", loadData, 32'hFFFFFF80);
      do_op(3'd1, 32'h103, 32'h0, 2);
      check("lbu_const", loadData, 32'h00000080);
      do_op(3'd6, 32'h102, 32'h0000A5C3, 0);
      do_op(3'd2, 32'h102, 32'h0, 0);
      check("lh_const", loadData, 32'hFFFFA5C3);
      do_op(3'd4, 32'h200, 32'h0, 10);
      check("to_ld", loadData, 32'hFFFFA5C3);
      do_op(3'd4, 32'h204, 32'h0, T - 1);
      do_op(3'd4, 32'h102, 32'h0, 0);

      @(negedge clock);
      start = 1'b1; op = 3'd4; address = 32'h10;
      @(negedge clock);
      start = 1'b0;
      check("pre_rst_rd", memRead, 1);
      @(negedge clock);
      #2 reset = 1'b0;
      #1 check("mid_rst", {memRead, busy, done, error}, 4'b0000);
      check("mid_rst_ld", loadData, 0);
      exp_ld = 32'd0;
      @(negedge clock);
      reset = 1'b1;
      do_op(3'd3, 32'h12, 32'h0, 1);

      for (int i = 0; i < 150; i++) begin
         do_op(3'($urandom_range(0, 7)), $urandom, $urandom,
               $urandom_range(0, T + 1));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
